// File: rtl/lsu_dc_arbiter_pkg.sv
// Shared types for the LSU data-cache port arbiter: requester sources, ROB tag
// and the registered port command.
package lsu_dc_arbiter_pkg;

    localparam int TAG_W = 6;

    typedef logic [TAG_W-1:0] procyon_tag_t;

    typedef enum logic [1:0] {
        SRC_LD   = 2'd0,
        SRC_ST   = 2'd1,
        SRC_FILL = 2'd2
    } lsu_dc_src_t;

    typedef struct packed {
        logic         valid;
        lsu_dc_src_t  src;
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   byte_en;
        procyon_tag_t tag;
    } lsu_dc_cmd_t;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_LD   = 0;
    localparam int GNT_ST   = 1;
    localparam int GNT_FILL = 2;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_dc_arb_pick.sv
// Combinational winner selection: FILL > ST > LD, except a starved load that
// is still eligible jumps ahead of both.
module lsu_dc_arb_pick
    import lsu_dc_arbiter_pkg::*;
(
    input  logic       slot_free_i,
    input  logic       ld_elig_i,
    input  logic       ld_starved_i,
    input  logic       st_req_i,
    input  logic       fill_req_i,
    output logic [2:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (slot_free_i) begin
            if (ld_elig_i && ld_starved_i) begin
                grant_o[GNT_LD] = 1'b1;
            end else if (fill_req_i) begin
                grant_o[GNT_FILL] = 1'b1;
            end else if (st_req_i) begin
                grant_o[GNT_ST] = 1'b1;
            end else if (ld_elig_i) begin
                grant_o[GNT_LD] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_dc_arbiter.sv
// Single data-cache port shared by EX loads, store-queue retirement and miss
// fills; one registered command in flight, response routed back by source.
module lsu_dc_arbiter
    import lsu_dc_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_flush,

    input  logic         i_ld_req,
    output logic         o_ld_ready,
    input  logic [31:0]  i_ld_addr,
    input  procyon_tag_t i_ld_tag,
    output logic         o_ld_resp_valid,
    output logic         o_ld_resp_hit,
    output logic [31:0]  o_ld_resp_data,
    output procyon_tag_t o_ld_resp_tag,

    input  logic         i_st_req,
    output logic         o_st_ready,
    input  logic [31:0]  i_st_addr,
    input  logic [31:0]  i_st_data,
    input  logic [3:0]   i_st_byte_en,
    output logic         o_st_resp_valid,
    output logic         o_st_resp_hit,

    input  logic         i_fill_req,
    output logic         o_fill_ready,
    input  logic [31:0]  i_fill_addr,
    input  logic [31:0]  i_fill_data,

    output logic         o_dc_en,
    output logic         o_dc_we,
    output logic [31:0]  o_dc_addr,
    output logic [31:0]  o_dc_data,
    output logic [3:0]   o_dc_byte_en,
    input  logic         i_dc_busy,
    input  logic         i_dc_hit,
    input  logic [31:0]  i_dc_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    lsu_dc_cmd_t      cmd_q, cmd_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [2:0]       grant;
    logic             accept;
    logic             slot_free;
    logic             ld_elig;
    logic             ld_squash;

    assign accept    = cmd_q.valid && !i_dc_busy;
    assign slot_free = !cmd_q.valid || accept;
    assign ld_elig   = i_ld_req && !i_flush;
    assign ld_squash = i_flush && cmd_q.valid && (cmd_q.src == SRC_LD);

    lsu_dc_arb_pick u_pick (
        .slot_free_i  (slot_free),
        .ld_elig_i    (ld_elig),
        .ld_starved_i (starve_cnt_q == CNT_MAX),
        .st_req_i     (i_st_req),
        .fill_req_i   (i_fill_req),
        .grant_o      (grant)
    );

    assign o_ld_ready   = grant[GNT_LD];
    assign o_st_ready   = grant[GNT_ST];
    assign o_fill_ready = grant[GNT_FILL];

    // Retired or squashed commands are zeroed so the idle port reads all-zero
    always_comb begin
        cmd_d = cmd_q;
        if (accept || ld_squash) begin
            cmd_d = '0;
        end
        if (grant[GNT_FILL]) begin
            cmd_d = '{valid: 1'b1, src: SRC_FILL, we: 1'b1, addr: i_fill_addr,
                      data: i_fill_data, byte_en: BE_WORD, tag: '0};
        end else if (grant[GNT_ST]) begin
            cmd_d = '{valid: 1'b1, src: SRC_ST, we: 1'b1, addr: i_st_addr,
                      data: i_st_data, byte_en: i_st_byte_en, tag: '0};
        end else if (grant[GNT_LD]) begin
            cmd_d = '{valid: 1'b1, src: SRC_LD, we: 1'b0, addr: i_ld_addr,
                      data: '0, byte_en: BE_WORD, tag: i_ld_tag};
        end
    end

    // Counts only free slots a live load lost; busy cycles and flush cycles hold
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_ld_req || grant[GNT_LD]) begin
            starve_cnt_d = '0;
        end else if (ld_elig && slot_free && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cmd_q        <= '0;
            starve_cnt_q <= '0;
        end else begin
            cmd_q        <= cmd_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign o_dc_en      = cmd_q.valid;
    assign o_dc_we      = cmd_q.we;
    assign o_dc_addr    = cmd_q.addr;
    assign o_dc_data    = cmd_q.data;
    assign o_dc_byte_en = cmd_q.byte_en;

    assign o_ld_resp_valid = accept && (cmd_q.src == SRC_LD) && !i_flush;
    assign o_ld_resp_hit   = o_ld_resp_valid && i_dc_hit;
    assign o_ld_resp_data  = o_ld_resp_valid ? i_dc_data : '0;
    assign o_ld_resp_tag   = o_ld_resp_valid ? cmd_q.tag : '0;

    assign o_st_resp_valid = accept && (cmd_q.src == SRC_ST);
    assign o_st_resp_hit   = o_st_resp_valid && i_dc_hit;

endmodule
